// File: rtl/uart_cmd_decoder.sv
// Byte-stream command decoder: "L<h><h>CR" sets the LED register and answers "OK"/"ER" CR LF.
// Define UART_CMD_QUERY_EN to add the "?CR" query that reports the LED value as two hex digits.
module uart_cmd_decoder #(
    parameter int LED_W       = 6,
    parameter int TIMEOUT_CYC = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_valid,
    output logic             rx_data_ready,
    output logic [7:0]       tx_data,
    output logic             tx_data_valid,
    input  logic             tx_data_ready,
    output logic [LED_W-1:0] led,
    output logic             cmd_strobe
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_L_UP = 8'h4C;
    localparam logic [7:0] CH_L_LO = 8'h6C;
    localparam logic [7:0] CH_O    = 8'h4F;
    localparam logic [7:0] CH_K    = 8'h4B;
    localparam logic [7:0] CH_E    = 8'h45;
    localparam logic [7:0] CH_R    = 8'h52;
`ifdef UART_CMD_QUERY_EN
    localparam logic [7:0] CH_QM   = 8'h3F;
`endif

    // Both directions use valid/ready: a byte moves on the rising edge where valid && ready.
    // The decoder refuses input only while it is sending a response.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARG_HI  = 3'd1,
        ARG_LO  = 3'd2,
        WAIT_CR = 3'd3,
        DROP    = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t           state;
    logic [3:0]       nib_hi;
    logic [3:0]       nib_lo;
    logic [CNT_W-1:0] idle_cnt;
    logic [23:0]      resp_rest;
    logic [1:0]       resp_left;
    logic             accept;
    logic [4:0]       rx_hex;
`ifdef UART_CMD_QUERY_EN
    logic             is_query;
    logic [7:0]       led_ext;
`endif

    // bit 4 flags a valid hex digit, bits 3:0 carry its value
    function automatic logic [4:0] hex_val(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39)
            return {1'b1, b[3:0]};
        else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            return {1'b1, b[3:0] + 4'd9};
        else
            return 5'd0;
    endfunction

`ifdef UART_CMD_QUERY_EN
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return {4'h3, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    always_comb begin
        led_ext = '0;
        led_ext[LED_W-1:0] = led;
    end
`endif

    assign rx_data_ready = (state != RESP);
    assign accept        = rx_data_valid && rx_data_ready;
    assign rx_hex        = hex_val(rx_data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            led           <= '0;
            cmd_strobe    <= 1'b0;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            idle_cnt      <= '0;
            nib_hi        <= '0;
            nib_lo        <= '0;
            resp_rest     <= '0;
            resp_left     <= '0;
`ifdef UART_CMD_QUERY_EN
            is_query      <= 1'b0;
`endif
        end else begin
            cmd_strobe <= 1'b0;

            // A partial command is abandoned after TIMEOUT_CYC cycles without an accepted byte.
            if ((state == ARG_HI || state == ARG_LO || state == WAIT_CR || state == DROP) && !accept) begin
                if (idle_cnt == TO_LAST) begin
                    idle_cnt <= '0;
                    state    <= IDLE;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (rx_data == CH_L_UP || rx_data == CH_L_LO) begin
                            state <= ARG_HI;
`ifdef UART_CMD_QUERY_EN
                            is_query <= 1'b0;
`endif
                        end
`ifdef UART_CMD_QUERY_EN
                        else if (rx_data == CH_QM) begin
                            is_query <= 1'b1;
                            state    <= WAIT_CR;
                        end
`endif
                        else if (rx_data == CH_CR || rx_data == CH_LF || rx_data == CH_SP) begin
                            state <= IDLE;
                        end else begin
                            state <= DROP;
                        end
                    end
                end

                ARG_HI: begin
                    if (accept) begin
                        if (rx_hex[4]) begin
                            nib_hi <= rx_hex[3:0];
                            state  <= ARG_LO;
                        end else begin
                            state <= DROP;
                        end
                    end
                end

                ARG_LO: begin
                    if (accept) begin
                        if (rx_hex[4]) begin
                            nib_lo <= rx_hex[3:0];
                            state  <= WAIT_CR;
                        end else begin
                            state <= DROP;
                        end
                    end
                end

                WAIT_CR: begin
                    if (accept) begin
                        if (rx_data == CH_CR) begin
                            state         <= RESP;
                            tx_data_valid <= 1'b1;
                            resp_left     <= 2'd3;
`ifdef UART_CMD_QUERY_EN
                            if (is_query) begin
                                tx_data   <= hex_char(led_ext[7:4]);
                                resp_rest <= {hex_char(led_ext[3:0]), CH_CR, CH_LF};
                            end else
`endif
                            begin
                                led        <= LED_W'({nib_hi, nib_lo});
                                cmd_strobe <= 1'b1;
                                tx_data    <= CH_O;
                                resp_rest  <= {CH_K, CH_CR, CH_LF};
                            end
                        end else begin
                            state <= DROP;
                        end
                    end
                end

                DROP: begin
                    if (accept && rx_data == CH_CR) begin
                        state         <= RESP;
                        tx_data_valid <= 1'b1;
                        tx_data       <= CH_E;
                        resp_rest     <= {CH_R, CH_CR, CH_LF};
                        resp_left     <= 2'd3;
                    end
                end

                RESP: begin
                    // tx_data is the byte on offer; resp_rest holds the rest, oldest in the top byte
                    if (tx_data_valid && tx_data_ready) begin
                        if (resp_left == 2'd0) begin
                            tx_data_valid <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            tx_data   <= resp_rest[23:16];
                            resp_rest <= {resp_rest[15:0], 8'h00};
                            resp_left <= resp_left - 2'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomised and directed bench for uart_cmd_decoder; a line-level reference model fills
// the expected tx-byte and LED queues, and a monitor on the clock's falling edge drains them.
module tb_uart_cmd_decoder;

    localparam int LED_W = 6;
    localparam int TO    = 100;

    logic             clk;
    logic             rst_n;
    logic [7:0]       rx_data;
    logic             rx_data_valid;
    logic             rx_data_ready;
    logic [7:0]       tx_data;
    logic             tx_data_valid;
    logic             tx_data_ready;
    logic [LED_W-1:0] led;
    logic             cmd_strobe;

    uart_cmd_decoder #(.LED_W(LED_W), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_ready(tx_data_ready),
        .led          (led),
        .cmd_strobe   (cmd_strobe)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int               n_tests = 0;
    int               n_fail  = 0;
    int               n_strobes = 0;
    int               exp_strobes = 0;
    logic [7:0]       exp_q[$];
    logic [LED_W-1:0] exp_led_q[$];
    logic [7:0]       line_q[$];
    logic [LED_W-1:0] model_led = '0;
    bit               tx_rand = 1'b0;
    bit               prev_stall = 1'b0;
    logic [7:0]       prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (works on whole lines) ----------------
    function automatic bit is_hex(input logic [7:0] b);
        return (b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f");
    endfunction

    function automatic logic [3:0] hex_num(input logic [7:0] b);
        if (b >= "0" && b <= "9") return 4'(b - "0");
        if (b >= "A" && b <= "F") return 4'(b - "A" + 10);
        return 4'(b - "a" + 10);
    endfunction

    function automatic logic [7:0] hex_chr(input int n);
        return (n < 10) ? 8'("0" + n) : 8'("A" + n - 10);
    endfunction

    function automatic bit is_l(input logic [7:0] b);
        return b == "L" || b == "l";
    endfunction

    task automatic respond(input logic [7:0] b0, input logic [7:0] b1);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // A CR ends the pending line, except when the line is an unfinished "L", "Lh" prefix:
    // then that CR is itself the bad byte and the error waits for a later CR.
    task automatic model_accept(input logic [7:0] b);
        int v;
        if (b == 8'h0D) begin
            if (line_q.size() == 0) return;
            if ((line_q.size() == 1 && is_l(line_q[0])) ||
                (line_q.size() == 2 && is_l(line_q[0]) && is_hex(line_q[1]))) begin
                line_q.push_back(b);
                return;
            end
            if (line_q.size() == 3 && is_l(line_q[0]) && is_hex(line_q[1]) && is_hex(line_q[2])) begin
                v = hex_num(line_q[1]) * 16 + hex_num(line_q[2]);
                model_led = LED_W'(v % (1 << LED_W));
                exp_led_q.push_back(model_led);
                exp_strobes++;
                respond("O", "K");
            end
`ifdef UART_CMD_QUERY_EN
            else if (line_q.size() == 1 && line_q[0] == "?") begin
                v = int'(model_led);
                respond(hex_chr(v / 16), hex_chr(v % 16));
            end
`endif
            else begin
                respond("E", "R");
            end
            line_q.delete();
        end else if (line_q.size() == 0 && (b == 8'h0A || b == 8'h20)) begin
            // blank filler between commands
        end else begin
            line_q.push_back(b);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        int guard;
        rx_data       = b;
        rx_data_valid = 1'b1;
        guard         = 0;
        forever begin
            @(negedge clk);
            if (rx_data_ready) break;
            guard++;
            if (guard > 500) begin
                check("rx_accept_timeout", 32'd0, 32'd1);
                rx_data_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        model_accept(b);
        rx_data_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] rand_hex();
        int v = $urandom_range(0, 15);
        if (v < 10) return 8'("0" + v);
        return $urandom_range(0, 1) ? 8'("A" + v - 10) : 8'("a" + v - 10);
    endfunction

    always @(posedge clk) begin
        #1;
        if (tx_rand) tx_data_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_strobe) begin
                n_strobes++;
                if (exp_led_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
                else check("led", 32'(led), 32'(exp_led_q.pop_front()));
            end
            if (prev_stall) check("tx_hold", {23'd0, tx_data_valid, tx_data}, {23'd0, 1'b1, prev_data});
            if (tx_data_valid) begin
                check("rx_ready_in_resp", 32'(rx_data_ready), 32'd0);
                if (tx_data_ready) begin
                    if (exp_q.size() == 0) check("unexpected_tx", 32'(tx_data), 32'hFFFF);
                    else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = tx_data_valid && !tx_data_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        int kind;
        rst_n         = 1'b0;
        rx_data       = '0;
        rx_data_valid = 1'b0;
        tx_data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_led", 32'(led), 32'd0);
        check("rst_tx_valid", 32'(tx_data_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_strobe", 32'(cmd_strobe), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rx_ready_after_rst", 32'(rx_data_ready), 32'd1);

        // basic set, lower-case and truncation, invalid hex
        send_str("L2A"); send_byte(8'h0D); drain();
        check("led_2a", 32'(led), 32'h2A);
        send_byte(8'h0A);
        send_str("lf3"); send_byte(8'h0D); drain();
        check("led_33", 32'(led), 32'h33);
        send_str("LG1"); send_byte(8'h0D); drain();
        check("led_kept_after_err", 32'(led), 32'h33);

        // transmitter stalls during the OK response
        tx_data_ready = 1'b0;
        send_str("L15"); send_byte(8'h0D);
        guard = 0;
        while (!tx_data_valid && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("stall_first_byte", {23'd0, tx_data_valid, tx_data}, {23'd0, 1'b1, 8'h4F});
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("stall_still_4f", 32'(tx_data), 32'h4F);
        tx_data_ready = 1'b1;
        drain();

        // abandoned partial command
        send_str("L1");
        repeat (TO + 20) begin
            @(posedge clk);
            #1;
        end
        check("timeout_no_tx", 32'(tx_data_valid), 32'd0);
        line_q.delete();
        send_str("L05"); send_byte(8'h0D); drain();
        check("led_05", 32'(led), 32'h05);

        // query (or error when the query is not built in)
        send_str("L2A"); send_byte(8'h0D);
        send_str("?"); send_byte(8'h0D); drain();
        check("led_after_query", 32'(led), 32'h2A);

        // random traffic with a random transmitter
        tx_rand = 1'b1;
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: begin
                    send_byte($urandom_range(0, 1) ? "L" : "l");
                    send_byte(rand_hex());
                    send_byte(rand_hex());
                    send_byte(8'h0D);
                end
                2: begin
                    repeat ($urandom_range(1, 4)) send_byte(8'($urandom_range(0, 255)));
                    send_byte(8'h0D);
                end
                3: begin
                    send_byte("?");
                    send_byte(8'h0D);
                end
                4: begin
                    repeat ($urandom_range(1, 3)) begin
                        case ($urandom_range(0, 2))
                            0: send_byte(8'h20);
                            1: send_byte(8'h0A);
                            default: send_byte(8'h0D);
                        endcase
                    end
                end
                default: begin
                    send_byte("L");
                    if ($urandom_range(0, 1)) send_byte(rand_hex());
                    send_byte(8'h0D);
                end
            endcase
        end
        send_byte(8'h0D);
        send_byte(8'h0D);
        tx_rand = 1'b0;
        tx_data_ready = 1'b1;
        drain();

        // reset in the middle of a response
        send_str("L2A"); send_byte(8'h0D);
        guard = 0;
        forever begin
            @(negedge clk);
            if (tx_data_valid && tx_data_ready) break;
            guard++;
            if (guard > 20) break;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midresp_tx_valid", 32'(tx_data_valid), 32'd0);
        check("midresp_led", 32'(led), 32'd0);
        exp_q.delete();
        exp_led_q.delete();
        line_q.delete();
        model_led = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("midresp_no_more_tx", 32'(tx_data_valid), 32'd0);
        check("midresp_rx_ready", 32'(rx_data_ready), 32'd1);

        check("exp_q_empty", exp_q.size(), 0);
        check("led_q_empty", exp_led_q.size(), 0);
        check("strobe_count", n_strobes, exp_strobes);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
